// File: rtl/buffer_scanner.sv
// Sweeps all 2**ADDR_W locations of the circular sample buffer oldest-first and
// reports min/max (with first-occurrence scan offsets), sum, mean and peak-to-peak.
`timescale 1ns/1ps
module buffer_scanner #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  output logic [ADDR_W-1:0]        read_addr,
  input  logic [DATA_W-1:0]        sample_out,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W-1:0]        min_val,
  output logic [ADDR_W-1:0]        min_idx,
  output logic [DATA_W-1:0]        max_val,
  output logic [ADDR_W-1:0]        max_idx,
  output logic [DATA_W+ADDR_W-1:0] sum,
  output logic [DATA_W-1:0]        mean,
  output logic [DATA_W-1:0]        p2p
);

  localparam int SUM_W = DATA_W + ADDR_W;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   acc_idx_q, acc_idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [RD_LAT-1:0]   vld_q;
  logic                acc_en;

  logic [DATA_W-1:0]   amin_q, amin_d, amax_q, amax_d;
  logic [ADDR_W-1:0]   amin_idx_q, amin_idx_d, amax_idx_q, amax_idx_d;
  logic [SUM_W-1:0]    asum_q, asum_d;

  logic [DATA_W-1:0]   min_val_q, min_val_d, max_val_q, max_val_d;
  logic [ADDR_W-1:0]   min_idx_q, min_idx_d, max_idx_q, max_idx_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [DATA_W-1:0]   mean_q, mean_d, p2p_q, p2p_d;

  function automatic logic [DATA_W-1:0] mean_of(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] span_of(input logic [DATA_W-1:0] hi,
                                                input logic [DATA_W-1:0] lo);
    return hi - lo;
  endfunction

  // Tags the cycle whose sample_out belongs to the scan; its head gates accumulation.
  assign acc_en = vld_q[RD_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= (state_q == ISSUE);
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      acc_idx_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      amin_q     <= '0;
      amax_q     <= '0;
      amin_idx_q <= '0;
      amax_idx_q <= '0;
      asum_q     <= '0;
      min_val_q  <= '0;
      min_idx_q  <= '0;
      max_val_q  <= '0;
      max_idx_q  <= '0;
      sum_q      <= '0;
      mean_q     <= '0;
      p2p_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      acc_idx_q  <= acc_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      amin_q     <= amin_d;
      amax_q     <= amax_d;
      amin_idx_q <= amin_idx_d;
      amax_idx_q <= amax_idx_d;
      asum_q     <= asum_d;
      min_val_q  <= min_val_d;
      min_idx_q  <= min_idx_d;
      max_val_q  <= max_val_d;
      max_idx_q  <= max_idx_d;
      sum_q      <= sum_d;
      mean_q     <= mean_d;
      p2p_q      <= p2p_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    acc_idx_d  = acc_idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    amin_d     = amin_q;
    amax_d     = amax_q;
    amin_idx_d = amin_idx_q;
    amax_idx_d = amax_idx_q;
    asum_d     = asum_q;
    min_val_d  = min_val_q;
    min_idx_d  = min_idx_q;
    max_val_d  = max_val_q;
    max_idx_d  = max_idx_q;
    sum_d      = sum_q;
    mean_d     = mean_q;
    p2p_d      = p2p_q;

    // Strict compares keep the earliest offset on ties; offset 0 seeds everything.
    if (acc_en) begin
      acc_idx_d = acc_idx_q + ADDR_W'(1);
      if (acc_idx_q == '0) begin
        amin_d     = sample_out;
        amax_d     = sample_out;
        amin_idx_d = '0;
        amax_idx_d = '0;
        asum_d     = SUM_W'(sample_out);
      end else begin
        asum_d = asum_q + SUM_W'(sample_out);
        if (sample_out < amin_q) begin
          amin_d     = sample_out;
          amin_idx_d = acc_idx_q;
        end
        if (sample_out > amax_q) begin
          amax_d     = sample_out;
          amax_idx_d = acc_idx_q;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d    = base_addr;
          cnt_d     = '0;
          acc_idx_d = '0;
          busy_d    = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (acc_en && (acc_idx_q == {ADDR_W{1'b1}})) state_d = FINISH;
      end
      FINISH: begin
        min_val_d = amin_q;
        min_idx_d = amin_idx_q;
        max_val_d = amax_q;
        max_idx_d = amax_idx_q;
        sum_d     = asum_q;
        mean_d    = mean_of(asum_q);
        p2p_d     = span_of(amax_q, amin_q);
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign read_addr = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign min_val   = min_val_q;
  assign min_idx   = min_idx_q;
  assign max_val   = max_val_q;
  assign max_idx   = max_idx_q;
  assign sum       = sum_q;
  assign mean      = mean_q;
  assign p2p       = p2p_q;

endmodule

// File: tb/tb_buffer_scanner.sv
// Bench for buffer_scanner: buffer memory model, scan-level reference model with a
// per-cycle compare, and directed scenarios with hand-computed results.
`timescale 1ns/1ps
module tb_buffer_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start = 1'b0, start2 = 1'b0;
  logic [7:0]  base_addr = 8'd0, base2 = 8'd0;

  logic [7:0]  read_addr, read_addr2;
  logic [15:0] sample_out, sample_out2, s2_a;
  logic        busy, done, busy2, done2;
  logic [15:0] min_val, max_val, mean, p2p, min_val2, max_val2, mean2, p2p2;
  logic [7:0]  min_idx, max_idx, min_idx2, max_idx2;
  logic [23:0] sum, sum2;

  logic [15:0] mem [256];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  buffer_scanner #(.DATA_W(16), .ADDR_W(8), .RD_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .read_addr(read_addr), .sample_out(sample_out), .busy(busy), .done(done),
    .min_val(min_val), .min_idx(min_idx), .max_val(max_val), .max_idx(max_idx),
    .sum(sum), .mean(mean), .p2p(p2p)
  );

  buffer_scanner #(.DATA_W(16), .ADDR_W(8), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .base_addr(base2),
    .read_addr(read_addr2), .sample_out(sample_out2), .busy(busy2), .done(done2),
    .min_val(min_val2), .min_idx(min_idx2), .max_val(max_val2), .max_idx(max_idx2),
    .sum(sum2), .mean(mean2), .p2p(p2p2)
  );

  // Buffer read ports: one-cycle and two-cycle latency.
  always @(posedge clk) sample_out <= mem[read_addr];
  always @(posedge clk) begin
    s2_a        <= mem[read_addr2];
    sample_out2 <= s2_a;
  end

  typedef struct packed {
    logic [15:0] mn;
    logic [7:0]  mni;
    logic [15:0] mx;
    logic [7:0]  mxi;
    logic [23:0] sm;
  } res_t;

  function automatic res_t scan_ref(input logic [7:0] b);
    res_t r;
    logic [15:0] v;
    logic [7:0]  a;
    r = '0;
    for (int k = 0; k < 256; k++) begin
      a = b + 8'(k);
      v = mem[a];
      r.sm = r.sm + 24'(v);
      if (k == 0 || v < r.mn) begin
        r.mn  = v;
        r.mni = 8'(k);
      end
      if (k == 0 || v > r.mx) begin
        r.mx  = v;
        r.mxi = 8'(k);
      end
    end
    return r;
  endfunction

  // Scan-level model (RD_LAT=1): busy from acceptance edge E0 until done at E258.
  logic       m_act, m_done;
  int         m_t;
  logic [7:0] m_base, m_addr;
  res_t       m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act  <= 1'b0;
      m_done <= 1'b0;
      m_t    <= 0;
      m_base <= 8'd0;
      m_addr <= 8'd0;
      m_res  <= '0;
    end else if (!m_act) begin
      m_done <= 1'b0;
      if (start) begin
        m_act  <= 1'b1;
        m_t    <= 0;
        m_base <= base_addr;
        m_addr <= base_addr;
      end
    end else begin
      m_t <= m_t + 1;
      if (m_t + 1 <= 255) m_addr <= m_base + 8'(m_t + 1);
      if (m_t + 1 == 258) begin
        m_act  <= 1'b0;
        m_done <= 1'b1;
        m_res  <= scan_ref(m_base);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("read_addr", 32'(read_addr), 32'(m_addr));
    chk("busy", 32'(busy), 32'(m_act));
    chk("done", 32'(done), 32'(m_done));
    chk("min_val", 32'(min_val), 32'(m_res.mn));
    chk("min_idx", 32'(min_idx), 32'(m_res.mni));
    chk("max_val", 32'(max_val), 32'(m_res.mx));
    chk("max_idx", 32'(max_idx), 32'(m_res.mxi));
    chk("sum", 32'(sum), 32'(m_res.sm));
    chk("mean", 32'(mean), 32'(m_res.sm[23:8]));
    chk("p2p", 32'(p2p), 32'(m_res.mx - m_res.mn));
  end

  task automatic start_scan(input bit which, input logic [7:0] b, output int e0);
    @(negedge clk);
    if (which) begin base2 = b; start2 = 1'b1; end
    else begin base_addr = b; start = 1'b1; end
    @(posedge clk);
    #1;
    e0 = cyc;
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input bit which, input string nm, output int edge_n);
    int n;
    n = 0;
    edge_n = -1;
    while (n < 400 && edge_n < 0) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (which ? done2 : done) edge_n = cyc;
    end
    if (edge_n < 0) begin
      checks++;
      errors++;
      $display("FAIL %s no done within 400 cycles", nm);
    end
  endtask

  task automatic chk_res(input bit which, input string tag,
                         input logic [15:0] mn, input logic [7:0] mni,
                         input logic [15:0] mx, input logic [7:0] mxi,
                         input logic [23:0] sm, input logic [15:0] mu,
                         input logic [15:0] pp);
    chk({tag, "_min"},  32'(which ? min_val2 : min_val), 32'(mn));
    chk({tag, "_mini"}, 32'(which ? min_idx2 : min_idx), 32'(mni));
    chk({tag, "_max"},  32'(which ? max_val2 : max_val), 32'(mx));
    chk({tag, "_maxi"}, 32'(which ? max_idx2 : max_idx), 32'(mxi));
    chk({tag, "_sum"},  32'(which ? sum2 : sum), 32'(sm));
    chk({tag, "_mean"}, 32'(which ? mean2 : mean), 32'(mu));
    chk({tag, "_p2p"},  32'(which ? p2p2 : p2p), 32'(pp));
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
  endtask

  task automatic fill_const(input logic [15:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  initial begin
    int e0, e1, de, de2;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    fill_ramp();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(read_addr), 0);
    chk("rst_sum", 32'(sum), 0);
    rst_n = 1'b1;

    // Ramp, base 0.
    start_scan(0, 8'd0, e0);
    wait_done(0, "ramp", de);
    chk("ramp_done_edge", 32'(de - e0), 258);
    chk_res(0, "ramp", 16'd0, 8'd0, 16'd255, 8'd255, 24'd32640, 16'd127, 16'd255);

    // 270 writes into a 256-deep ring, oldest at 14.
    for (int i = 0; i < 270; i++) mem[i % 256] = 16'(i);
    start_scan(0, 8'd14, e0);
    wait_done(0, "wrap", de);
    chk_res(0, "wrap", 16'd14, 8'd0, 16'd269, 8'd255, 24'd36224, 16'd141, 16'd255);

    fill_const(16'hFFFF);
    start_scan(0, 8'd0, e0);
    wait_done(0, "ones", de);
    chk_res(0, "ones", 16'hFFFF, 8'd0, 16'hFFFF, 8'd0, 24'd16776960, 16'hFFFF, 16'd0);

    fill_const(16'h8000);
    start_scan(0, 8'd77, e0);
    wait_done(0, "half", de);
    chk_res(0, "half", 16'h8000, 8'd0, 16'h8000, 8'd0, 24'd8388608, 16'h8000, 16'd0);

    // Start re-pulsed at E50 must be ignored.
    fill_ramp();
    start_scan(0, 8'd0, e0);
    repeat (49) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, "repulse", de);
    chk("repulse_done_edge", 32'(de - e0), 258);
    chk_res(0, "repulse", 16'd0, 8'd0, 16'd255, 8'd255, 24'd32640, 16'd127, 16'd255);

    // Start held high through done launches a second scan.
    @(negedge clk);
    base_addr = 8'd0;
    start = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    wait_done(0, "held1", de);
    chk("held1_done_edge", 32'(de - e0), 258);
    @(posedge clk);
    #1 e1 = cyc;
    start = 1'b0;
    wait_done(0, "held2", de2);
    chk("held2_done_edge", 32'(de2 - e1), 258);
    chk("held_gap", 32'(de2 - de), 259);

    // Asynchronous abort at E100.
    start_scan(0, 8'd0, e0);
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_addr", 32'(read_addr), 0);
    chk_res(0, "abort", 16'd0, 8'd0, 16'd0, 8'd0, 24'd0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 0);
    end
    start_scan(0, 8'd0, e0);
    wait_done(0, "after_abort", de);
    chk("after_abort_edge", 32'(de - e0), 258);
    chk_res(0, "after_abort", 16'd0, 8'd0, 16'd255, 8'd255, 24'd32640, 16'd127, 16'd255);

    // Two-cycle read latency instance.
    start_scan(1, 8'd0, e0);
    wait_done(1, "lat2", de);
    chk("lat2_done_edge", 32'(de - e0), 259);
    chk_res(1, "lat2", 16'd0, 8'd0, 16'd255, 8'd255, 24'd32640, 16'd127, 16'd255);
    @(negedge clk);
    chk("lat2_done_pulse", 32'(done2), 0);
    chk("lat2_busy_low", 32'(busy2), 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buffer_scanner.md
Name: buffer_scanner

Overview:
Downstream consumer of the 256-entry circular sample buffer. On a start request it sweeps every buffer location once, oldest sample first, by driving the buffer's read_addr from a caller-supplied base pointer with wrap-around. It computes min, max (with scan indices), sum, mean and peak-to-peak over the sweep and presents the results with a one-cycle done pulse. Samples are treated as unsigned.

Parameters:
DATA_W, 16, sample width (matches buffer sample_out)
ADDR_W, 8, buffer address width; DEPTH = 2**ADDR_W samples per scan
RD_LAT, 1, buffer read latency in cycles from read_addr to valid sample_out (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  scan request, sampled only in IDLE
base_addr  in  ADDR_W  physical address of the oldest sample; latched on accepted start
read_addr  out  ADDR_W  address to buffer read port
sample_out  in  DATA_W  buffer read data, valid RD_LAT cycles after read_addr
busy  out  1  high while a scan is in progress
done  out  1  one-cycle pulse, results valid
min_val  out  DATA_W  smallest sample
min_idx  out  ADDR_W  scan offset (0..DEPTH-1) of first min
max_val  out  DATA_W  largest sample
max_idx  out  ADDR_W  scan offset of first max
sum  out  DATA_W+ADDR_W  sum of all DEPTH samples
mean  out  DATA_W  sum >> ADDR_W, truncated
p2p  out  DATA_W  max_val - min_val

Behaviour:
- Reset (async, rst_n low): state IDLE; read_addr, busy, done, all result outputs = 0; internal accumulators and the valid pipeline cleared.
- States: IDLE -> ISSUE -> DRAIN -> FINISH -> IDLE.
- IDLE: start=1 at edge E0 -> latch base_addr, read_addr <= base_addr, issue counter = 0, busy <= 1, go ISSUE.
- ISSUE: one address per cycle; read_addr = (base + k) mod DEPTH for k = 0..DEPTH-1, natural ADDR_W wrap. After address DEPTH-1 is issued, go DRAIN; read_addr holds the last issued value.
- Valid pipeline: RD_LAT-deep shift register tags cycles whose sample_out belongs to the scan. Sample for offset k is accumulated at edge E(k+RD_LAT+1).
- Accumulation: running min and max use strict compare (< / >), so ties keep the earliest offset. The first sample (k=0) initialises min and max with idx 0. sum is DATA_W+ADDR_W bits wide and cannot overflow.
- DRAIN: wait until the last sample is accumulated, then FINISH.
- FINISH: results registered to outputs, done <= 1 for exactly one cycle, busy <= 0, state IDLE. Both take effect at edge E(DEPTH+RD_LAT+1); with defaults that is E258.
- Result outputs hold until the next done; they do not change mid-scan.
- start while busy is ignored, not queued. start asserted in the cycle done is high is accepted, since the state is IDLE then.
- rst_n low mid-scan aborts immediately: outputs zeroed, no done. A new start after release runs a full scan.
- base_addr changes after acceptance have no effect on the current scan.

Test Plan:
- Buffer model (RD_LAT=1) holds addr k = k, base_addr=0, start pulse -> read_addr 0..255 on consecutive cycles. done at E258 for one cycle. min 0/idx 0, max 255/idx 255, sum 32640, mean 127, p2p 255. busy high E0..E257.
- Wrap: 270 writes of i (addr k holds k+256 for k<14, else k), base_addr=14 -> read_addr 14..255,0..13. min 14/idx 0, max 269/idx 255, sum 36224, mean 141, p2p 255.
- All samples 0xFFFF -> min=max=0xFFFF, both idx 0, sum 16776960, mean 0xFFFF, p2p 0. Then all 0x8000 -> sum 8388608, mean 0x8000.
- start re-pulsed at E50 during a scan -> ignored: single done at E258, results equal the single-scan values. start held high through done -> second scan starts, second done 258 cycles later.
- rst_n low at E100 mid-scan -> busy, done and all outputs 0 immediately, no done pulse. After release, start -> correct full-scan results.
- RD_LAT=2 build, ramp data -> done at E259, results identical to the first scenario.
